vip_dehaze_recover: RTL and testbench

- Back end of the dark-channel-prior dehaze chain: consumes the original RGB888 stream plus its co-timed dark-channel byte, and reconstructs the dehazed RGB888 pixel J = A + (I - A)/t.
- Estimates atmospheric light A once per frame as the maximum dark value. Computes 65536/A with a sequential divider during vertical blanking.
- Per-pixel transmission t and 1/t come from a 4-stage pipeline; sync signals are delayed to match.

---
 rtl/vip_dehaze_pkg.sv | 26 ++
 rtl/vip_dehaze_recover_if.sv | 35 +++
 rtl/vip_recip_lut.sv | 23 ++
 rtl/vip_dehaze_recover.sv | 200 ++++++++++++++++++++
 tb/tb_vip_dehaze_recover.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vip_dehaze_pkg.sv
// Shared constants, divider state type and reciprocal helper for the dehaze back end.
package vip_dehaze_pkg;

  localparam int unsigned RECIP_NUM = 65536;
  localparam int unsigned RECIP_MAX = 65535;
  localparam int unsigned PIPE_LAT  = 4;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } div_state_t;

  // 65536/t saturated to 16 bits; t=0 maps to the saturated value.
  function automatic logic [15:0] recip16(input logic [7:0] t);
    int unsigned q;
    if (t == 8'd0) begin
      q = RECIP_MAX;
    end else begin
      q = RECIP_NUM / 32'(t);
      if (q > RECIP_MAX) q = RECIP_MAX;
    end
    return 16'(q);
  endfunction

endpackage

// File: rtl/vip_dehaze_recover_if.sv
// Pixel stream bundle: original RGB + dark channel in, dehazed RGB out.
interface vip_dehaze_recover_if;

  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_red;
  logic [7:0] per_img_green;
  logic [7:0] per_img_blue;
  logic [7:0] per_dark;

  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_red;
  logic [7:0] post_img_green;
  logic [7:0] post_img_blue;

  // Source side: drives the input stream, observes the recovered stream.
  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output per_img_red, per_img_green, per_img_blue, per_dark,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_img_red, post_img_green, post_img_blue
  );

  // Recovery block side.
  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  per_img_red, per_img_green, per_img_blue, per_dark,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_img_red, post_img_green, post_img_blue
  );

endinterface

// File: rtl/vip_recip_lut.sv
// 256x16 registered reciprocal ROM: data = 65536/addr saturated, one clock read latency.
module vip_recip_lut
  import vip_dehaze_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  output logic [15:0] data
);

  logic [15:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = recip16(8'(i));
  end

  // Registered read; cleared with the rest of the pixel pipeline.
  always_ff @(posedge clk) begin
    if (rst) data <= '0;
    else     data <= rom[addr];
  end

endmodule

// File: rtl/vip_dehaze_recover.sv
// Dehaze recovery: J = A + (I - A)/t with per-frame atmospheric light A and 4-stage pipeline.
module vip_dehaze_recover
  import vip_dehaze_pkg::*;
#(
  parameter int unsigned OMEGA  = 243,
  parameter int unsigned T0     = 26,
  parameter int unsigned A_INIT = 255
) (
  input logic                 clk,
  input logic                 rst,
  vip_dehaze_recover_if.slave bus
);

  localparam logic [7:0]  A_RST       = 8'(A_INIT);
  localparam logic [15:0] RECIP_A_RST = recip16(A_RST);
  localparam logic [7:0]  T_MIN       = 8'(T0);

  // Sync delay lines; taps 0/1 double as the vsync edge detector.
  logic [PIPE_LAT-1:0] vs_dl, hr_dl, ck_dl;
  logic                rise;

  // Pixel pipeline registers.
  logic [7:0]  s1_ph, s1_r, s1_g, s1_b;
  logic [7:0]  s2_t, s2_a, s2_r, s2_g, s2_b;
  logic [7:0]  s3_a, s3_r, s3_g, s3_b;
  logic [15:0] s3_recip;
  logic [7:0]  out_r, out_g, out_b;
  logic [15:0] ratio_full;
  logic [7:0]  ratio, t_raw, t_new;

  // Frame statistics and divider.
  div_state_t  state_q, state_d;
  logic [7:0]  max_q, max_d;
  logic [7:0]  a_next_q, a_next_d;
  logic [7:0]  a_cur_q, a_cur_d;
  logic [15:0] recip_a_q, recip_a_d;
  logic [7:0]  rem_q, rem_d;
  logic [16:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [8:0]  trial;

  // S4 per-channel recovery: clamp(A + floor((I - A) * recipT / 256), 0, 255).
  function automatic logic [7:0] recover(input logic [7:0] i, input logic [7:0] a,
                                         input logic [15:0] rt);
    logic signed [8:0]  d;
    logic signed [25:0] prod;
    logic signed [17:0] s;
    logic signed [18:0] j;
    d    = $signed({1'b0, i}) - $signed({1'b0, a});
    prod = $signed({{17{d[8]}}, d}) * $signed({10'd0, rt});
    s    = 18'(prod >>> 8);
    j    = $signed({11'd0, a}) + $signed({s[17], s});
    if (j < 0)                 return 8'd0;
    else if (j > 19'sd255)     return 8'd255;
    else                       return j[7:0];
  endfunction

  assign rise = vs_dl[0] & ~vs_dl[1];

  assign bus.post_frame_vsync = vs_dl[PIPE_LAT-1];
  assign bus.post_frame_href  = hr_dl[PIPE_LAT-1];
  assign bus.post_frame_clken = ck_dl[PIPE_LAT-1];
  assign bus.post_img_red     = out_r;
  assign bus.post_img_green   = out_g;
  assign bus.post_img_blue    = out_b;

  // Sync delay lines, matched to the pixel pipeline latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_dl <= '0;
      hr_dl <= '0;
      ck_dl <= '0;
    end else begin
      vs_dl <= {vs_dl[PIPE_LAT-2:0], bus.per_frame_vsync};
      hr_dl <= {hr_dl[PIPE_LAT-2:0], bus.per_frame_href};
      ck_dl <= {ck_dl[PIPE_LAT-2:0], bus.per_frame_clken};
    end
  end

  // S2 transmission: t = max(T0, 255 - min(255, (p>>8) * recipA >> 8)).
  always_comb begin
    ratio_full = 16'((24'(s1_ph) * 24'(recip_a_q)) >> 8);
    ratio      = (ratio_full > 16'd255) ? 8'd255 : ratio_full[7:0];
    t_raw      = 8'd255 - ratio;
    t_new      = (t_raw < T_MIN) ? T_MIN : t_raw;
  end

  // Pixel pipeline S1, S2, S3 side-band and S4; advances every clock regardless of clken.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ph <= '0; s1_r <= '0; s1_g <= '0; s1_b <= '0;
      s2_t  <= '0; s2_a <= '0; s2_r <= '0; s2_g <= '0; s2_b <= '0;
      s3_a  <= '0; s3_r <= '0; s3_g <= '0; s3_b <= '0;
      out_r <= '0; out_g <= '0; out_b <= '0;
    end else begin
      s1_ph <= 8'((16'(bus.per_dark) * 16'(OMEGA)) >> 8);
      s1_r  <= bus.per_img_red;
      s1_g  <= bus.per_img_green;
      s1_b  <= bus.per_img_blue;
      // A is captured here and travels with the pixel so a commit never splits one pixel.
      s2_t  <= t_new;
      s2_a  <= a_cur_q;
      s2_r  <= s1_r;
      s2_g  <= s1_g;
      s2_b  <= s1_b;
      s3_a  <= s2_a;
      s3_r  <= s2_r;
      s3_g  <= s2_g;
      s3_b  <= s2_b;
      out_r <= recover(s3_r, s3_a, s3_recip);
      out_g <= recover(s3_g, s3_a, s3_recip);
      out_b <= recover(s3_b, s3_a, s3_recip);
    end
  end

  // S3 reciprocal of transmission.
  vip_recip_lut u_recip_lut (
    .clk  (clk),
    .rst  (rst),
    .addr (s2_t),
    .data (s3_recip)
  );

  // Frame max tracking and restoring divider 65536 / A_next, one quotient bit per clock.
  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    a_next_d  = a_next_q;
    a_cur_d   = a_cur_q;
    recip_a_d = recip_a_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    trial     = '0;

    if (rise) begin
      max_d = '0;
    end else if (bus.per_frame_href && bus.per_frame_clken && bus.per_dark > max_q) begin
      max_d = bus.per_dark;
    end

    unique case (state_q)
      IDLE: ;
      DIV: begin
        // Dividend 65536 has only its MSB set, fed in on the first step.
        trial = {rem_q, (cnt_q == 5'd0)};
        if (trial >= {1'b0, a_next_q}) begin
          rem_d = 8'(trial - {1'b0, a_next_q});
          quo_d = {quo_q[15:0], 1'b1};
        end else begin
          rem_d = trial[7:0];
          quo_d = {quo_q[15:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd16) state_d = DONE;
      end
      DONE: begin
        a_cur_d   = a_next_q;
        recip_a_d = quo_q[16] ? 16'(RECIP_MAX) : quo_q[15:0];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new edge restarts the divide and discards any run in flight, including its commit.
    if (rise) begin
      state_d   = DIV;
      a_next_d  = (max_q == 8'd0) ? 8'd1 : max_q;
      rem_d     = '0;
      quo_d     = '0;
      cnt_d     = '0;
      a_cur_d   = a_cur_q;
      recip_a_d = recip_a_q;
    end
  end

  // Divider and atmospheric light state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      max_q     <= '0;
      a_next_q  <= '0;
      a_cur_q   <= A_RST;
      recip_a_q <= RECIP_A_RST;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      a_next_q  <= a_next_d;
      a_cur_q   <= a_cur_d;
      recip_a_q <= recip_a_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vip_dehaze_recover.sv
// Self-checking bench for vip_dehaze_recover: vector table, hand sequences, random frames.
module tb_vip_dehaze_recover;
  import vip_dehaze_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vip_dehaze_recover_if bus ();

  vip_dehaze_recover dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst, vs, hr, ck;
    logic [7:0] r, g, b, dark;
    int         a, ra;
  } hist_t;

  typedef struct {
    logic [7:0] r, g, b, dark;
    logic [7:0] er, eg, eb;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  hist_t hist [8];

  // Reference model of atmospheric light.
  int   a_m, ra_m, max_m, a_next_m, due;
  logic vs_prev_m;

  function automatic int recip_ref(int x);
    int q;
    if (x == 0) return 65535;
    q = 65536 / x;
    return (q > 65535) ? 65535 : q;
  endfunction

  function automatic int ref_j(int i, int a, int ra, int dark);
    int p, ratio, t, rt, s, j;
    p     = dark * 243;
    ratio = ((p / 256) * ra) / 256;
    if (ratio > 255) ratio = 255;
    t = 255 - ratio;
    if (t < 26) t = 26;
    rt = recip_ref(t);
    s  = ((i - a) * rt) >>> 8;
    j  = a + s;
    if (j < 0) j = 0;
    if (j > 255) j = 255;
    return j;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input hist_t h);
    if (h.rst) begin
      a_m = 255; ra_m = recip_ref(255); max_m = 0; due = -1; vs_prev_m = 1'b0;
    end else begin
      if (due == cyc) begin
        a_m = a_next_m; ra_m = recip_ref(a_next_m); due = -1;
      end
      if (h.hr && h.ck && h.dark > max_m) max_m = h.dark;
      if (h.vs && !vs_prev_m) begin
        a_next_m = (max_m == 0) ? 1 : max_m;
        max_m    = 0;
        due      = cyc + 19;
      end
      vs_prev_m = h.vs;
    end
  endtask

  // One clock: sample after the edge, advance the model, compare every output.
  task automatic step();
    hist_t h, p, s2;
    bit    clean;
    @(posedge clk);
    #1;
    h.rst = rst; h.vs = bus.per_frame_vsync; h.hr = bus.per_frame_href;
    h.ck = bus.per_frame_clken; h.r = bus.per_img_red; h.g = bus.per_img_green;
    h.b = bus.per_img_blue; h.dark = bus.per_dark; h.a = a_m; h.ra = ra_m;
    hist[cyc % 8] = h;
    model_edge(h);
    clean = (cyc >= 3);
    for (int k = 0; k < 4; k++) if (cyc >= k && hist[(cyc - k) % 8].rst) clean = 1'b0;
    if (!clean) begin
      check("vsync_rst", bus.post_frame_vsync, 0);
      check("href_rst", bus.post_frame_href, 0);
      check("clken_rst", bus.post_frame_clken, 0);
      check("rgb_rst", {bus.post_img_red, bus.post_img_green, bus.post_img_blue}, 0);
    end else begin
      p  = hist[(cyc - 3) % 8];
      s2 = hist[(cyc - 2) % 8];
      check("vsync_dly", bus.post_frame_vsync, p.vs);
      check("href_dly", bus.post_frame_href, p.hr);
      check("clken_dly", bus.post_frame_clken, p.ck);
      if (p.ck) begin
        check("red", bus.post_img_red, ref_j(p.r, s2.a, s2.ra, p.dark));
        check("green", bus.post_img_green, ref_j(p.g, s2.a, s2.ra, p.dark));
        check("blue", bus.post_img_blue, ref_j(p.b, s2.a, s2.ra, p.dark));
      end
    end
    check("a_cur", dut.a_cur_q, a_m);
    check("recip_a", dut.recip_a_q, ra_m);
    cyc++;
  endtask

  task automatic set_pix(input logic hr, input logic ck, input logic [7:0] dark,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.per_frame_href  = hr;
    bus.per_frame_clken = ck;
    bus.per_dark        = dark;
    bus.per_img_red     = r;
    bus.per_img_green   = g;
    bus.per_img_blue    = b;
  endtask

  // Non-line cycles with random pixels still flowing (clken high so outputs are checked).
  task automatic blank(input int n, input logic vs);
    bus.per_frame_vsync = vs;
    for (int k = 0; k < n; k++) begin
      set_pix(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
    bus.per_frame_vsync = 1'b0;
  endtask

  // Active line whose dark maximum is exactly dmax.
  task automatic line(input int len, input int dmax);
    for (int k = 0; k < len; k++) begin
      set_pix(1'b1, 1'b1, (k == len / 2) ? 8'(dmax) : 8'($urandom_range(0, dmax)),
              8'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
  endtask

  // Vsync pulse with explicit commit-timing checks relative to the rising edge.
  task automatic vs_commit(input int n, input int old_a, input int exp_a, input int exp_ra);
    bus.per_frame_vsync = 1'b1;
    for (int k = 0; k < n; k++) begin
      set_pix(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      step();
      if (k == 18) check("a_before_commit", dut.a_cur_q, old_a);
      if (k == 19) begin
        check("a_commit", dut.a_cur_q, exp_a);
        check("recip_a_commit", dut.recip_a_q, exp_ra);
      end
    end
    bus.per_frame_vsync = 1'b0;
  endtask

  task automatic rand_frame();
    int lines, len;
    lines = 2 + $urandom_range(0, 2);
    for (int l = 0; l < lines; l++) begin
      blank(2 + $urandom_range(0, 2), 1'b0);
      len = 8 + $urandom_range(0, 12);
      for (int x = 0; x < len; x++) begin
        set_pix(1'b1, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom));
        step();
      end
    end
    blank(2, 1'b0);
    blank(19 + $urandom_range(0, 11), 1'b1);
    blank(2, 1'b0);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{8'd100, 8'd100, 8'd100, 8'd0,   8'd99,  8'd99, 8'd99};
    tbl[1] = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd41,  8'd41, 8'd41};
    tbl[2] = '{8'd0,   8'd0,   8'd0,   8'd255, 8'd0,   8'd0,  8'd0};
    tbl[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    tbl[4] = '{8'd10,  8'd128, 8'd250, 8'd50,  8'd0,   8'd98, 8'd248};
    tbl[5] = '{8'd255, 8'd0,   8'd250, 8'd255, 8'd255, 8'd0,  8'd205};

    rst = 1'b1;
    bus.per_frame_vsync = 1'b0;
    set_pix(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) step();
    check("reset_state_idle", dut.state_q == IDLE, 1);
    check("reset_a_cur", dut.a_cur_q, 255);
    rst = 1'b0;

    // Hold each vector for the pipeline depth, then compare the settled output.
    for (int i = 0; i < 6; i++) begin
      set_pix(1'b1, 1'b1, tbl[i].dark, tbl[i].r, tbl[i].g, tbl[i].b);
      repeat (4) step();
      check("tbl_red", bus.post_img_red, tbl[i].er);
      check("tbl_green", bus.post_img_green, tbl[i].eg);
      check("tbl_blue", bus.post_img_blue, tbl[i].eb);
    end

    // Single clken pulse must appear at the output exactly four clocks later.
    set_pix(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (4) step();
    bus.per_frame_clken = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      bus.per_frame_clken = 1'b0;
      check("clken_pulse", bus.post_frame_clken, (k == 3) ? 1 : 0);
    end

    // Frame with dark max 255 from the table, then a frame with max 128.
    blank(2, 1'b0);
    vs_commit(25, 255, 255, 257);
    blank(2, 1'b0);
    line(10, 128);
    blank(2, 1'b0);
    vs_commit(30, 255, 128, 512);
    blank(2, 1'b0);

    // All-zero dark frame forces A to 1.
    for (int k = 0; k < 8; k++) begin
      set_pix(1'b1, 1'b1, 8'd0, 8'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
    blank(2, 1'b0);
    vs_commit(25, 128, 1, 65535);
    blank(2, 1'b0);

    // Short vsync pulse, then a second edge: only the second run may commit.
    line(8, 200);
    blank(2, 1'b0);
    blank(5, 1'b1);
    blank(2, 1'b0);
    line(6, 77);
    blank(2, 1'b0);
    vs_commit(30, 1, 77, 851);
    blank(2, 1'b0);

    // Reset while the divider runs, then a normal frame.
    line(8, 150);
    blank(2, 1'b0);
    blank(8, 1'b1);
    rst = 1'b1;
    blank(2, 1'b0);
    check("rst_div_idle", dut.state_q == IDLE, 1);
    check("rst_div_a", dut.a_cur_q, 255);
    rst = 1'b0;
    blank(4, 1'b0);
    line(8, 90);
    blank(2, 1'b0);
    vs_commit(25, 255, 90, 728);
    blank(2, 1'b0);

    for (int f = 0; f < 5; f++) rand_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
